ahb_sram_ctrl: RTL and testbench

AHB_SRAM_CTRL -- requirements
Module: ahb_sram_ctrl

---
 rtl/ahb_sram_ctrl_if.sv | 23 ++
 rtl/ahb_sram_ctrl.sv | 160 ++++++++++++++++
 tb/tb_ahb_sram_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/ahb_sram_ctrl_if.sv
// AHB-Lite slave request/response bundle used by ahb_sram_ctrl.
interface ahb_sram_ctrl_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic        HRESP;

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HREADYOUT, HRDATA, HRESP
    );

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HREADYOUT, HRDATA, HRESP
    );
endinterface

// File: rtl/ahb_sram_ctrl.sv
// Zero-wait AHB-Lite to single-port SRAM bridge with a one-entry write buffer
// and read-after-write forwarding. Optional range check: AHB_SRAM_CTRL_RANGE_CHK_EN.
module ahb_sram_ctrl #(
    parameter int unsigned DEPTH_WORDS = 3072
) (
    input  logic           HCLK,
    input  logic           HRESETn,
    ahb_sram_ctrl_if.slave ahb,
    input  logic [31:0]    SRAMRDATA,
    output logic [11:0]    SRAMADDR,
    output logic [3:0]     SRAMWEN,
    output logic [31:0]    SRAMWDATA,
    output logic           SRAMCS0
);

    function automatic logic [3:0] size_lanes(input logic [2:0] size, input logic [1:0] lsb);
        logic [3:0] lanes;
        if (size == 3'd0)      lanes = 4'b0001 << lsb;
        else if (size == 3'd1) lanes = lsb[1] ? 4'b1100 : 4'b0011;
        else                   lanes = 4'b1111;
        return lanes;
    endfunction

    logic        addr_valid;
    logic        in_range;
    logic        rd_acc;
    logic        wr_acc;
    logic        commit;
    logic [11:0] word_addr;
    logic [3:0]  req_lanes;
    logic [31:0] commit_data;

    logic        wp_valid_q,  wp_valid_d;
    logic        wp_dphase_q, wp_dphase_d;
    logic        rd_dphase_q, rd_dphase_d;
    logic [3:0]  fwd_lanes_q, fwd_lanes_d;
    logic [11:0] wp_addr_q,   wp_addr_d;
    logic [3:0]  wp_lanes_q,  wp_lanes_d;
    logic [31:0] wp_data_q,   wp_data_d;

    assign addr_valid = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];
    assign word_addr  = ahb.HADDR[13:2];
    assign req_lanes  = size_lanes(ahb.HSIZE, ahb.HADDR[1:0]);

    // Everything is gated by HRESETn so a transfer caught by reset never reaches the SRAM.
    assign rd_acc = HRESETn & addr_valid & in_range & ~ahb.HWRITE;
    assign wr_acc = HRESETn & addr_valid & in_range &  ahb.HWRITE;
    assign commit = HRESETn & wp_valid_q & ~rd_acc;

    // In the write's own data phase the data is still on HWDATA, not yet in the buffer.
    assign commit_data = wp_dphase_q ? ahb.HWDATA : wp_data_q;

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        wp_valid_d  = wp_valid_q;
        wp_addr_d   = wp_addr_q;
        wp_lanes_d  = wp_lanes_q;
        wp_data_d   = wp_dphase_q ? ahb.HWDATA : wp_data_q;
        wp_dphase_d = wr_acc;
        rd_dphase_d = rd_acc;
        fwd_lanes_d = 4'b0000;

        if (commit) begin
            wp_valid_d = 1'b0;
        end
        if (wr_acc) begin
            wp_valid_d = 1'b1;
            wp_addr_d  = word_addr;
            wp_lanes_d = req_lanes;
        end
        // A read always blocks the commit, so a pending match is necessarily uncommitted.
        if (rd_acc && wp_valid_q && (wp_addr_q == word_addr)) begin
            fwd_lanes_d = wp_lanes_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            wp_valid_q  <= 1'b0;
            wp_dphase_q <= 1'b0;
            rd_dphase_q <= 1'b0;
            fwd_lanes_q <= 4'b0000;
        end else begin
            wp_valid_q  <= wp_valid_d;
            wp_dphase_q <= wp_dphase_d;
            rd_dphase_q <= rd_dphase_d;
            fwd_lanes_q <= fwd_lanes_d;
        end
    end

    // NOTE: buffer payload is left unreset; wp_valid_q qualifies every use of it.
    always_ff @(posedge HCLK) begin
        wp_addr_q  <= wp_addr_d;
        wp_lanes_q <= wp_lanes_d;
        wp_data_q  <= wp_data_d;
    end

    always_comb begin
        SRAMCS0    = rd_acc | commit;
        SRAMADDR   = 12'h000;
        SRAMWEN    = 4'b0000;
        SRAMWDATA  = 32'h0000_0000;
        ahb.HRDATA = 32'h0000_0000;

        if (rd_acc) begin
            SRAMADDR = word_addr;
        end else if (commit) begin
            SRAMADDR  = wp_addr_q;
            SRAMWEN   = wp_lanes_q;
            SRAMWDATA = commit_data;
        end

        if (HRESETn && rd_dphase_q) begin
            for (int i = 0; i < 4; i++) begin
                ahb.HRDATA[8*i +: 8] = fwd_lanes_q[i] ? wp_data_q[8*i +: 8] : SRAMRDATA[8*i +: 8];
            end
        end
    end

`ifdef AHB_SRAM_CTRL_RANGE_CHK_EN
    typedef enum logic [1:0] {
        ST_OKAY = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } err_state_e;

    err_state_e err_q, err_d;
    logic       err_req;
    logic       unused_bits;

    assign in_range    = ({2'b00, ahb.HADDR[31:2]} < DEPTH_WORDS);
    assign err_req     = HRESETn & addr_valid & ~in_range;
    assign unused_bits = ahb.HTRANS[0];

    always_comb begin
        err_d = err_q;
        case (err_q)
            ST_ERR1: err_d = ST_ERR2;
            default: err_d = err_req ? ST_ERR1 : ST_OKAY;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) err_q <= ST_OKAY;
        else          err_q <= err_d;
    end

    assign ahb.HREADYOUT = ~HRESETn | (err_q != ST_ERR1);
    assign ahb.HRESP     =  HRESETn & (err_q != ST_OKAY);
`else
    logic unused_bits;

    assign in_range      = 1'b1;
    assign unused_bits   = ^{ahb.HTRANS[0], ahb.HADDR[31:14], DEPTH_WORDS[0]};
    assign ahb.HREADYOUT = 1'b1;
    assign ahb.HRESP     = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// Directed, table-driven bench for ahb_sram_ctrl with a behavioural SRAM model.
module tb_ahb_sram_ctrl;
    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_BUSY = 2'b01;
    localparam logic [1:0] T_NSEQ = 2'b10;
    localparam int         NV     = 27;

    typedef struct {
        logic        poke;
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        cs;
        logic [3:0]  wen;
        logic [11:0] saddr;
        logic [31:0] swdata;
        logic [31:0] rdata;
    } vec_t;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [31:0] SRAMRDATA;
    logic [11:0] SRAMADDR;
    logic [3:0]  SRAMWEN;
    logic [31:0] SRAMWDATA;
    logic        SRAMCS0;
    logic [31:0] mem [0:4095];
    logic        bad_040;
    int          pass_cnt = 0;
    int          total_cnt = 0;
    vec_t        vecs [NV];

    ahb_sram_ctrl_if bus ();
    assign bus.HREADY = bus.HREADYOUT;

    ahb_sram_ctrl #(.DEPTH_WORDS(3072)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .ahb       (bus),
        .SRAMRDATA (SRAMRDATA),
        .SRAMADDR  (SRAMADDR),
        .SRAMWEN   (SRAMWEN),
        .SRAMWDATA (SRAMWDATA),
        .SRAMCS0   (SRAMCS0)
    );

    always #5 HCLK = ~HCLK;

    // SRAM model: one-cycle read latency, byte-lane writes.
    always @(posedge HCLK) begin
        if (SRAMCS0) begin
            if (SRAMWEN == 4'b0000) SRAMRDATA <= mem[SRAMADDR];
            else begin
                for (int i = 0; i < 4; i++)
                    if (SRAMWEN[i]) mem[SRAMADDR][8*i +: 8] <= SRAMWDATA[8*i +: 8];
            end
        end
    end

    always @(negedge HCLK) begin
        if (SRAMCS0 && (SRAMWEN != 4'b0000) && (SRAMADDR == 12'h010)) bad_040 <= 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic chk_out(input string n, input logic cs, input logic [3:0] wen,
                           input logic [11:0] sa, input logic [31:0] wd, input logic [31:0] rd,
                           input logic rdy, input logic rsp);
        check($sformatf("%s.cs", n), {31'b0, SRAMCS0}, {31'b0, cs});
        check($sformatf("%s.wen", n), {28'b0, SRAMWEN}, {28'b0, wen});
        if (cs) check($sformatf("%s.addr", n), {20'b0, SRAMADDR}, {20'b0, sa});
        check($sformatf("%s.wdata", n), SRAMWDATA, wd);
        check($sformatf("%s.hrdata", n), bus.HRDATA, rd);
        check($sformatf("%s.hreadyout", n), {31'b0, bus.HREADYOUT}, {31'b0, rdy});
        check($sformatf("%s.hresp", n), {31'b0, bus.HRESP}, {31'b0, rsp});
    endtask

    // Drives one cycle of inputs just after the rising edge, returns at the falling edge.
    task automatic cyc(input logic rstn, input logic sel, input logic [1:0] trans, input logic wr,
                       input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        @(posedge HCLK);
        #1;
        HRESETn    = rstn;
        bus.HSEL   = sel;
        bus.HTRANS = trans;
        bus.HWRITE = wr;
        bus.HSIZE  = size;
        bus.HADDR  = addr;
        bus.HWDATA = wdata;
        @(negedge HCLK);
    endtask

    function automatic vec_t v(input logic sel, input logic [1:0] tr, input logic wr,
                               input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd,
                               input logic cs, input logic [3:0] wen, input logic [11:0] sa,
                               input logic [31:0] swd, input logic [31:0] rd);
        vec_t r;
        r.poke = 1'b0; r.sel = sel; r.trans = tr; r.wr = wr; r.size = sz; r.addr = a;
        r.wdata = wd; r.cs = cs; r.wen = wen; r.saddr = sa; r.swdata = swd; r.rdata = rd;
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] <= 32'h0;
        SRAMRDATA  <= 32'h0;
        bad_040    <= 1'b0;
        HRESETn    = 1'b0;
        bus.HSEL   = 1'b0;
        bus.HTRANS = T_IDLE;
        bus.HWRITE = 1'b0;
        bus.HSIZE  = 3'd0;
        bus.HADDR  = 32'h0;
        bus.HWDATA = 32'h0;

        //        sel trans  wr sz addr          hwdata         cs wen   saddr   swdata         hrdata
        vecs[0]  = v(1, T_NSEQ, 1, 2, 32'h010, 32'h0,         0, 4'h0, 12'h000, 32'h0,         32'h0);
        vecs[1]  = v(0, T_IDLE, 0, 0, 32'h000, 32'hDEADBEEF,  1, 4'hF, 12'h004, 32'hDEADBEEF,  32'h0);
        vecs[2]  = v(0, T_IDLE, 0, 0, 32'h000, 32'h0,         0, 4'h0, 12'h000, 32'h0,         32'h0);
        vecs[3]  = v(1, T_NSEQ, 1, 2, 32'h020, 32'h0,         0, 4'h0, 12'h000, 32'h0,         32'h0);
        vecs[4]  = v(1, T_NSEQ, 0, 2, 32'h020, 32'h11223344,  1, 4'h0, 12'h008, 32'h0,         32'h0);
        vecs[5]  = v(0, T_IDLE, 0, 0, 32'h000, 32'h0,         1, 4'hF, 12'h008, 32'h11223344,  32'h11223344);
        vecs[6]  = v(0, T_IDLE, 0, 0, 32'h000, 32'h0,         0, 4'h0, 12'h000, 32'h0,         32'h0);
        vecs[7]  = v(1, T_NSEQ, 1, 0, 32'h023, 32'h0,         0, 4'h0, 12'h000, 32'h0,         32'h0);
        vecs[7].poke = 1'b1;
        vecs[8]  = v(1, T_NSEQ, 0, 1, 32'h020, 32'hAB000000,  1, 4'h0, 12'h008, 32'h0,         32'h0);
        vecs[9]  = v(0, T_IDLE, 0, 0, 32'h000, 32'h0,         1, 4'h8, 12'h008, 32'hAB000000,  32'hAB667788);
        vecs[10] = v(0, T_IDLE, 0, 0, 32'h000, 32'h0,         0, 4'h0, 12'h000, 32'h0,         32'h0);
        vecs[11] = v(1, T_NSEQ, 1, 2, 32'h000, 32'h0,         0, 4'h0, 12'h000, 32'h0,         32'h0);
        vecs[12] = v(1, T_NSEQ, 1, 2, 32'h004, 32'hA1A1A1A1,  1, 4'hF, 12'h000, 32'hA1A1A1A1,  32'h0);
        vecs[13] = v(1, T_NSEQ, 1, 2, 32'h008, 32'hB2B2B2B2,  1, 4'hF, 12'h001, 32'hB2B2B2B2,  32'h0);
        vecs[14] = v(0, T_IDLE, 0, 0, 32'h000, 32'hC3C3C3C3,  1, 4'hF, 12'h002, 32'hC3C3C3C3,  32'h0);
        vecs[15] = v(1, T_NSEQ, 0, 2, 32'h004, 32'h0,         1, 4'h0, 12'h001, 32'h0,         32'h0);
        vecs[16] = v(0, T_IDLE, 0, 0, 32'h000, 32'h0,         0, 4'h0, 12'h000, 32'h0,         32'hB2B2B2B2);
        vecs[17] = v(1, T_NSEQ, 0, 2, 32'h010, 32'h0,         1, 4'h0, 12'h004, 32'h0,         32'h0);
        vecs[18] = v(0, T_IDLE, 0, 0, 32'h000, 32'h0,         0, 4'h0, 12'h000, 32'h0,         32'hDEADBEEF);
        vecs[19] = v(0, T_NSEQ, 1, 2, 32'h100, 32'h0,         0, 4'h0, 12'h000, 32'h0,         32'h0);
        vecs[20] = v(0, T_IDLE, 0, 0, 32'h000, 32'hFFFFFFFF,  0, 4'h0, 12'h000, 32'h0,         32'h0);
        vecs[21] = v(1, T_BUSY, 1, 2, 32'h100, 32'h0,         0, 4'h0, 12'h000, 32'h0,         32'h0);
        vecs[22] = v(0, T_IDLE, 0, 0, 32'h000, 32'hFFFFFFFF,  0, 4'h0, 12'h000, 32'h0,         32'h0);
        vecs[23] = v(1, T_NSEQ, 1, 2, 32'h030, 32'h0,         0, 4'h0, 12'h000, 32'h0,         32'h0);
        vecs[24] = v(1, T_NSEQ, 0, 2, 32'h010, 32'h99999999,  1, 4'h0, 12'h004, 32'h0,         32'h0);
        vecs[25] = v(0, T_IDLE, 0, 0, 32'h000, 32'h0,         1, 4'hF, 12'h00C, 32'h99999999,  32'hDEADBEEF);
        vecs[26] = v(0, T_IDLE, 0, 0, 32'h000, 32'h0,         0, 4'h0, 12'h000, 32'h0,         32'h0);

        // Reset held with a valid read on the bus: nothing may reach the SRAM.
        cyc(0, 1, T_NSEQ, 0, 2, 32'h010, 32'h0);
        chk_out("rst_hold0", 0, 4'h0, 12'h000, 32'h0, 32'h0, 1, 0);
        cyc(0, 1, T_NSEQ, 0, 2, 32'h010, 32'h0);
        chk_out("rst_hold1", 0, 4'h0, 12'h000, 32'h0, 32'h0, 1, 0);
        cyc(1, 0, T_IDLE, 0, 0, 32'h0, 32'h0);
        chk_out("rst_exit", 0, 4'h0, 12'h000, 32'h0, 32'h0, 1, 0);

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].poke) mem[12'h008] <= 32'h55667788;
            cyc(1, vecs[i].sel, vecs[i].trans, vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wdata);
            chk_out($sformatf("vec%0d", i), vecs[i].cs, vecs[i].wen, vecs[i].saddr,
                    vecs[i].swdata, vecs[i].rdata, 1, 0);
        end

`ifdef AHB_SRAM_CTRL_RANGE_CHK_EN
        cyc(1, 1, T_NSEQ, 0, 2, 32'h3000, 32'h0);
        chk_out("oor_aphase", 0, 4'h0, 12'h000, 32'h0, 32'h0, 1, 0);
        cyc(1, 0, T_IDLE, 0, 0, 32'h0, 32'h0);
        chk_out("oor_err1", 0, 4'h0, 12'h000, 32'h0, 32'h0, 0, 1);
        cyc(1, 1, T_NSEQ, 0, 2, 32'h010, 32'h0);
        chk_out("oor_err2", 1, 4'h0, 12'h004, 32'h0, 32'h0, 1, 1);
        cyc(1, 0, T_IDLE, 0, 0, 32'h0, 32'h0);
        chk_out("oor_after", 0, 4'h0, 12'h000, 32'h0, 32'hDEADBEEF, 1, 0);
`else
        cyc(1, 1, T_NSEQ, 0, 2, 32'h3000, 32'h0);
        chk_out("wrap_aphase", 1, 4'h0, 12'hC00, 32'h0, 32'h0, 1, 0);
        cyc(1, 0, T_IDLE, 0, 0, 32'h0, 32'h0);
        chk_out("wrap_dphase", 0, 4'h0, 12'h000, 32'h0, 32'h0, 1, 0);
        cyc(1, 1, T_NSEQ, 0, 2, 32'hFFFFC010, 32'h0);
        chk_out("hibits_aphase", 1, 4'h0, 12'h004, 32'h0, 32'h0, 1, 0);
        cyc(1, 0, T_IDLE, 0, 0, 32'h0, 32'h0);
        chk_out("hibits_dphase", 0, 4'h0, 12'h000, 32'h0, 32'hDEADBEEF, 1, 0);
`endif

        // Reset lands in the data phase of write 0x040: the write must vanish.
        cyc(1, 1, T_NSEQ, 1, 2, 32'h040, 32'h0);
        chk_out("rstw_aphase", 0, 4'h0, 12'h000, 32'h0, 32'h0, 1, 0);
        cyc(0, 0, T_IDLE, 0, 0, 32'h0, 32'h0BAD0BAD);
        chk_out("rstw_dphase", 0, 4'h0, 12'h000, 32'h0, 32'h0, 1, 0);
        cyc(1, 0, T_IDLE, 0, 0, 32'h0, 32'h0BAD0BAD);
        chk_out("rstw_after", 0, 4'h0, 12'h000, 32'h0, 32'h0, 1, 0);
        cyc(1, 0, T_IDLE, 0, 0, 32'h0, 32'h0);
        chk_out("rstw_idle", 0, 4'h0, 12'h000, 32'h0, 32'h0, 1, 0);
        cyc(1, 1, T_NSEQ, 0, 2, 32'h040, 32'h0);
        chk_out("rstw_rd_a", 1, 4'h0, 12'h010, 32'h0, 32'h0, 1, 0);
        cyc(1, 0, T_IDLE, 0, 0, 32'h0, 32'h0);
        chk_out("rstw_rd_d", 0, 4'h0, 12'h000, 32'h0, 32'h0, 1, 0);
        check("rstw_no_write_040", {31'b0, bad_040}, 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
